// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the unified-RAM arbiter.
//   arb_state_e : arbiter FSM states (idle / read outstanding)
//   arb_owner_e : which requester owns the outstanding read
//   LAT_CNT_W   : width of the read-latency counter (covers RAM_LAT up to RAM_LAT_MAX)
//   GNT_*       : bit positions inside the one-hot grant vector
package mem_arb_pkg;

    typedef enum logic {
        ARB_IDLE    = 1'b0,
        ARB_RD_WAIT = 1'b1
    } arb_state_e;

    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_LD   = 2'd1,
        OWN_D    = 2'd2,
        OWN_I    = 2'd3
    } arb_owner_e;

    localparam int RAM_LAT_MAX = 3;
    localparam int LAT_CNT_W   = $clog2(RAM_LAT_MAX + 1);

    localparam int GNT_LD = 0;
    localparam int GNT_D  = 1;
    localparam int GNT_I  = 2;

endpackage

// File: rtl/mem_arb_pick.sv
// Combinational priority selector for the RAM arbiter.
//   i_ld_req, i_d_req, i_i_req : requests from loader, data port, fetch port
//   i_eligible                 : a grant may be issued this cycle
//   i_promote                  : fetch has starved long enough to beat the data port
//   o_gnt                      : one-hot grant, bit positions GNT_LD/GNT_D/GNT_I
module mem_arb_pick
    import mem_arb_pkg::*;
(
    input  logic       i_ld_req,
    input  logic       i_d_req,
    input  logic       i_i_req,
    input  logic       i_eligible,
    input  logic       i_promote,
    output logic [2:0] o_gnt
);

    // Fixed priority ld > d > i, with fetch lifted above data when promoted.
    always_comb begin
        o_gnt = 3'b000;
        if (!i_eligible) begin
            o_gnt = 3'b000;
        end else if (i_ld_req) begin
            o_gnt[GNT_LD] = 1'b1;
        end else if (i_promote && i_i_req) begin
            o_gnt[GNT_I] = 1'b1;
        end else if (i_d_req) begin
            o_gnt[GNT_D] = 1'b1;
        end else if (i_i_req) begin
            o_gnt[GNT_I] = 1'b1;
        end else begin
            o_gnt = 3'b000;
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Single-port unified RAM arbiter between the program loader (write-only),
// the MEM-stage data port (read/write) and the IF-stage fetch port (read-only).
//   ld_*     : loader write port; completes in its grant cycle
//   d_*      : data port request/grant and read return
//   i_*      : fetch port request/grant and read return
//   ram_*    : RAM pins, driven by the requester granted this cycle
//   stall_if / stall_mem : hold requests to the hazard logic
//   busy     : a read is outstanding
// Grants are combinational; read data returns RAM_LAT cycles after the grant,
// and that return cycle may already issue the next grant.
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int RAM_LAT    = 1,
    parameter int STARVE_MAX = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              ld_req,
    input  logic [ADDR_W-1:0] ld_addr,
    input  logic [DATA_W-1:0] ld_wdata,
    output logic              ld_gnt,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic              d_gnt,
    output logic              d_rvalid,
    output logic [DATA_W-1:0] d_rdata,
    input  logic              i_req,
    input  logic [ADDR_W-1:0] i_addr,
    output logic              i_gnt,
    output logic              i_rvalid,
    output logic [DATA_W-1:0] i_rdata,
    output logic              ram_en,
    output logic              ram_we,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_wdata,
    input  logic [DATA_W-1:0] ram_rdata,
    output logic              stall_if,
    output logic              stall_mem,
    output logic              busy
);

    localparam int STV_W = $clog2(STARVE_MAX + 1);

    arb_state_e           r_state, w_state_nxt;
    arb_owner_e           r_owner, w_owner_nxt;
    logic [LAT_CNT_W-1:0] r_cnt, w_cnt_nxt;
    logic [STV_W-1:0]     r_starve, w_starve_nxt;
    logic [DATA_W-1:0]    r_d_rdata, r_i_rdata;

    logic       w_ret, w_elig, w_promote, w_rd_gnt;
    logic       w_d_rvalid, w_i_rvalid;
    logic [2:0] w_gnt, w_gnt_out;

    // Data-return cycle: the counter has reached the RAM latency.
    assign w_ret     = (r_state == ARB_RD_WAIT) && (r_cnt == LAT_CNT_W'(RAM_LAT));
    assign w_elig    = (r_state == ARB_IDLE) || w_ret;
    assign w_promote = (r_starve == STV_W'(STARVE_MAX));

    mem_arb_pick u_pick (
        .i_ld_req   (ld_req),
        .i_d_req    (d_req),
        .i_i_req    (i_req),
        .i_eligible (w_elig),
        .i_promote  (w_promote),
        .o_gnt      (w_gnt)
    );

    // The flops are held by the async reset, so only the visible grants need
    // forcing low while rst_n is asserted.
    assign w_gnt_out  = w_gnt & {3{rst_n}};
    assign w_rd_gnt   = (w_gnt[GNT_D] && !d_we) || w_gnt[GNT_I];
    assign w_d_rvalid = w_ret && (r_owner == OWN_D);
    assign w_i_rvalid = w_ret && (r_owner == OWN_I);

    assign ld_gnt    = w_gnt_out[GNT_LD];
    assign d_gnt     = w_gnt_out[GNT_D];
    assign i_gnt     = w_gnt_out[GNT_I];
    assign d_rvalid  = w_d_rvalid;
    assign i_rvalid  = w_i_rvalid;
    assign d_rdata   = w_d_rvalid ? ram_rdata : r_d_rdata;
    assign i_rdata   = w_i_rvalid ? ram_rdata : r_i_rdata;
    assign ram_en    = |w_gnt_out;
    assign ram_we    = w_gnt_out[GNT_LD] || (w_gnt_out[GNT_D] && d_we);
    assign busy      = (r_state == ARB_RD_WAIT);
    assign stall_if  = rst_n && ((i_req && !w_gnt[GNT_I]) ||
                                 ((r_state == ARB_RD_WAIT) && (r_owner == OWN_I) && !w_i_rvalid));
    assign stall_mem = rst_n && ((d_req && !w_gnt[GNT_D]) ||
                                 ((r_state == ARB_RD_WAIT) && (r_owner == OWN_D) && !w_d_rvalid));

    // RAM address/data mux driven by whichever requester holds the grant.
    always_comb begin
        ram_addr  = '0;
        ram_wdata = '0;
        if (w_gnt_out[GNT_LD]) begin
            ram_addr  = ld_addr;
            ram_wdata = ld_wdata;
        end else if (w_gnt_out[GNT_D]) begin
            ram_addr  = d_addr;
            ram_wdata = d_wdata;
        end else if (w_gnt_out[GNT_I]) begin
            ram_addr  = i_addr;
            ram_wdata = '0;
        end else begin
            ram_addr  = '0;
            ram_wdata = '0;
        end
    end

    // Next-state logic: a read grant (re)arms the latency counter at 1.
    always_comb begin
        w_state_nxt = r_state;
        w_owner_nxt = r_owner;
        w_cnt_nxt   = r_cnt;
        case (r_state)
            ARB_IDLE: begin
                if (w_rd_gnt) begin
                    w_state_nxt = ARB_RD_WAIT;
                    w_owner_nxt = w_gnt[GNT_I] ? OWN_I : OWN_D;
                    w_cnt_nxt   = LAT_CNT_W'(1);
                end else begin
                    w_state_nxt = ARB_IDLE;
                    w_owner_nxt = OWN_NONE;
                    w_cnt_nxt   = '0;
                end
            end
            ARB_RD_WAIT: begin
                if (w_ret && w_rd_gnt) begin
                    w_state_nxt = ARB_RD_WAIT;
                    w_owner_nxt = w_gnt[GNT_I] ? OWN_I : OWN_D;
                    w_cnt_nxt   = LAT_CNT_W'(1);
                end else if (w_ret) begin
                    w_state_nxt = ARB_IDLE;
                    w_owner_nxt = OWN_NONE;
                    w_cnt_nxt   = '0;
                end else begin
                    w_cnt_nxt   = r_cnt + LAT_CNT_W'(1);
                end
            end
            default: begin
                w_state_nxt = ARB_IDLE;
                w_owner_nxt = OWN_NONE;
                w_cnt_nxt   = '0;
            end
        endcase
    end

    // Starvation counter: counts denied fetch cycles only while eligible.
    always_comb begin
        w_starve_nxt = r_starve;
        if (i_req && w_elig && !w_gnt[GNT_I]) begin
            if (r_starve != STV_W'(STARVE_MAX)) begin
                w_starve_nxt = r_starve + STV_W'(1);
            end else begin
                w_starve_nxt = r_starve;
            end
        end else if (w_gnt[GNT_I] || !i_req) begin
            w_starve_nxt = '0;
        end else begin
            w_starve_nxt = r_starve;
        end
    end

    // FSM, owner, counters and held read data registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= ARB_IDLE;
            r_owner   <= OWN_NONE;
            r_cnt     <= '0;
            r_starve  <= '0;
            r_d_rdata <= '0;
            r_i_rdata <= '0;
        end else begin
            r_state  <= w_state_nxt;
            r_owner  <= w_owner_nxt;
            r_cnt    <= w_cnt_nxt;
            r_starve <= w_starve_nxt;
            if (w_d_rvalid) begin
                r_d_rdata <= ram_rdata;
            end
            if (w_i_rvalid) begin
                r_i_rdata <= ram_rdata;
            end
        end
    end

endmodule
